// File: rtl/prf_wb_arbiter_if.sv
// Result-collection and PRF-write bundle for prf_wb_arbiter.
//   fu_valid/fu_prn/fu_data : per-unit result offer (master -> slave)
//   fu_ready                : per-unit FIFO space available (slave -> master)
//   wen/wprn/wdata          : registered PRF write / wakeup ports (slave -> master)
//   busy                    : results still buffered or being written
interface prf_wb_arbiter_if #(
  parameter int unsigned NUM_FU   = 6,
  parameter int unsigned W_PORTS  = 4,
  parameter int unsigned PRN_BITS = 6
);
  localparam int unsigned DATA_W = 64;

  logic [NUM_FU-1:0]                  fu_valid;
  logic [NUM_FU-1:0][PRN_BITS-1:0]    fu_prn;
  logic [NUM_FU-1:0][DATA_W-1:0]      fu_data;
  logic [NUM_FU-1:0]                  fu_ready;
  logic [W_PORTS-1:0]                 wen;
  logic [W_PORTS-1:0][PRN_BITS-1:0]   wprn;
  logic [W_PORTS-1:0][DATA_W-1:0]     wdata;
  logic                               busy;

  modport master (
    output fu_valid, fu_prn, fu_data,
    input  fu_ready, wen, wprn, wdata, busy
  );

  modport slave (
    input  fu_valid, fu_prn, fu_data,
    output fu_ready, wen, wprn, wdata, busy
  );
endinterface

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: buffers completed results from NUM_FU units in per-unit
// skid FIFOs and drains them round-robin onto W_PORTS registered PRF write
// ports (which also serve as the wakeup broadcast).
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   flush : synchronous squash of all buffered results
//   bus   : slave side of prf_wb_arbiter_if (unit results in, PRF writes out)
module prf_wb_arbiter #(
  parameter int unsigned NUM_FU     = 6,
  parameter int unsigned W_PORTS    = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PRN_BITS   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  prf_wb_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned RR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SCAN_W = RR_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned GNT_W  = $clog2(W_PORTS + 1);

  // FIFO state
  logic [NUM_FU-1:0][CNT_W-1:0] count;
  logic [NUM_FU-1:0][PTR_W-1:0] rd_ptr;
  logic [NUM_FU-1:0][PTR_W-1:0] wr_ptr;
  logic [PRN_BITS-1:0]          mem_prn  [NUM_FU][FIFO_DEPTH];
  logic [DATA_W-1:0]            mem_data [NUM_FU][FIFO_DEPTH];

  logic [NUM_FU-1:0]            ready;
  logic [NUM_FU-1:0]            nonempty;
  logic [NUM_FU-1:0]            push;
  logic [NUM_FU-1:0]            pop;
  logic [PRN_BITS-1:0]          head_prn  [NUM_FU];
  logic [DATA_W-1:0]            head_data [NUM_FU];

  // Arbitration state
  logic [RR_W-1:0]              rr_ptr;
  logic [RR_W-1:0]              rr_next;
  logic [RR_W-1:0]              last_src;
  logic                         any_grant;
  logic [GNT_W-1:0]             n_grant;
  logic [SCAN_W-1:0]            scan_sum;
  logic [RR_W-1:0]              scan_idx;
  logic [W_PORTS-1:0]           port_vld;
  logic [RR_W-1:0]              port_src [W_PORTS];

  // Output registers
  logic [W_PORTS-1:0]                wen_q;
  logic [W_PORTS-1:0][PRN_BITS-1:0]  wprn_q;
  logic [W_PORTS-1:0][DATA_W-1:0]    wdata_q;

  // Per-source status and heads; ready looks only at the registered count so
  // a full FIFO being popped this cycle still refuses the new entry.
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      ready[i]     = count[i] < CNT_W'(FIFO_DEPTH);
      nonempty[i]  = count[i] != '0;
      push[i]      = bus.fu_valid[i] & ready[i] & ~flush;
      head_prn[i]  = mem_prn[i][rd_ptr[i]];
      head_data[i] = mem_data[i][rd_ptr[i]];
    end
  end

  // Round-robin scan from rr_ptr; the k-th non-empty source found drives port k.
  always_comb begin
    pop       = '0;
    port_vld  = '0;
    last_src  = rr_ptr;
    any_grant = 1'b0;
    n_grant   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < W_PORTS; k++) begin
      port_src[k] = '0;
    end
    for (int unsigned j = 0; j < NUM_FU; j++) begin
      // rr_ptr + j < 2*NUM_FU, so one conditional subtract gives the modulo
      scan_sum = SCAN_W'(rr_ptr) + SCAN_W'(j);
      if (scan_sum >= SCAN_W'(NUM_FU)) begin
        scan_sum = scan_sum - SCAN_W'(NUM_FU);
      end
      scan_idx = RR_W'(scan_sum);
      if (nonempty[scan_idx] && (n_grant < GNT_W'(W_PORTS))) begin
        pop[scan_idx] = 1'b1;
        for (int unsigned k = 0; k < W_PORTS; k++) begin
          if (n_grant == GNT_W'(k)) begin
            port_vld[k] = 1'b1;
            port_src[k] = scan_idx;
          end
        end
        n_grant   = n_grant + GNT_W'(1);
        last_src  = scan_idx;
        any_grant = 1'b1;
      end
    end
  end

  assign rr_next = (last_src == RR_W'(NUM_FU - 1)) ? '0 : last_src + RR_W'(1);

  // Round-robin pointer: resumes after the last granted source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (!flush && any_grant) begin
      rr_ptr <= rr_next;
    end
  end

  // FIFO pointers and occupancy; flush empties every FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // FIFO storage, no reset needed: occupancy gates every read
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_prn[i][wr_ptr[i]]  <= bus.fu_prn[i];
        mem_data[i][wr_ptr[i]] <= bus.fu_data[i];
      end
    end
  end

  // Write ports: wen pulses one cycle per granted entry, PRN/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= '0;
      wprn_q  <= '0;
      wdata_q <= '0;
    end else if (flush) begin
      wen_q <= '0;
    end else begin
      wen_q <= port_vld;
      for (int unsigned k = 0; k < W_PORTS; k++) begin
        if (port_vld[k]) begin
          wprn_q[k]  <= head_prn[port_src[k]];
          wdata_q[k] <= head_data[port_src[k]];
        end
      end
    end
  end

  assign bus.fu_ready = ready;
  assign bus.wen      = wen_q;
  assign bus.wprn     = wprn_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy     = (|nonempty) | (|wen_q);

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Self-checking bench for prf_wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the writeback rules.
module tb_prf_wb_arbiter;
  localparam int NUM_FU     = 6;
  localparam int W_PORTS    = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int PRN_BITS   = 6;

  typedef struct {
    logic [PRN_BITS-1:0] prn;
    logic [63:0]         data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  prf_wb_arbiter_if #(.NUM_FU(NUM_FU), .W_PORTS(W_PORTS), .PRN_BITS(PRN_BITS)) bus ();

  prf_wb_arbiter #(
    .NUM_FU(NUM_FU), .W_PORTS(W_PORTS), .FIFO_DEPTH(FIFO_DEPTH), .PRN_BITS(PRN_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per unit, a round-robin start index, expected port values
  ent_t                q [NUM_FU][$];
  int                  rr;
  logic [W_PORTS-1:0]  exp_wen;
  logic [PRN_BITS-1:0] exp_prn  [W_PORTS];
  logic [63:0]         exp_data [W_PORTS];

  function automatic void model_reset();
    for (int i = 0; i < NUM_FU; i++) q[i].delete();
    rr = 0;
    exp_wen = '0;
    for (int k = 0; k < W_PORTS; k++) begin
      exp_prn[k]  = '0;
      exp_data[k] = '0;
    end
  endfunction

  function automatic logic [NUM_FU-1:0] model_ready();
    logic [NUM_FU-1:0] r;
    for (int i = 0; i < NUM_FU; i++) r[i] = (q[i].size() < FIFO_DEPTH);
    return r;
  endfunction

  function automatic logic model_busy();
    logic b;
    b = |exp_wen;
    for (int i = 0; i < NUM_FU; i++) if (q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // One clock edge of the writeback rules applied to the current inputs
  function automatic void model_edge();
    logic [NUM_FU-1:0] rdy;
    ent_t e;
    int n;
    int last;
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (flush) begin
      for (int i = 0; i < NUM_FU; i++) q[i].delete();
      exp_wen = '0;
      return;
    end
    rdy = model_ready();
    exp_wen = '0;
    n = 0;
    last = -1;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = (rr + j) % NUM_FU;
      if (n < W_PORTS && q[idx].size() > 0) begin
        e = q[idx].pop_front();
        exp_wen[n]  = 1'b1;
        exp_prn[n]  = e.prn;
        exp_data[n] = e.data;
        n++;
        last = idx;
      end
    end
    if (last >= 0) rr = (last + 1) % NUM_FU;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.fu_valid[i] && rdy[i]) begin
        e.prn  = bus.fu_prn[i];
        e.data = bus.fu_data[i];
        q[i].push_back(e);
      end
    end
  endfunction

  task automatic clear_inputs();
    bus.fu_valid = '0;
    bus.fu_prn   = '0;
    bus.fu_data  = '0;
    flush        = 1'b0;
  endtask

  task automatic offer(input int i, input logic [PRN_BITS-1:0] p, input logic [63:0] d);
    bus.fu_valid[i] = 1'b1;
    bus.fu_prn[i]   = p;
    bus.fu_data[i]  = d;
  endtask

  // Advance one edge, update the model, sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    checks++;
    if (bus.wen !== 4'b0000 || bus.fu_ready !== 6'b111111 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state wen=%b ready=%b busy=%b want 0000/111111/0", bus.wen, bus.fu_ready, bus.busy);
    end
    for (int i = 0; i < NUM_FU; i++) offer(i, PRN_BITS'(8 * i), 64'(100 + i));
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) offer(i, PRN_BITS'(8 * i + 1), 64'(200 + i));
    step();
    checks++;
    if (bus.wen !== 4'b1111) begin
      errors++;
      $display("FAIL reset_preload_wen got %b want 1111", bus.wen);
    end
    // asynchronous reset in the middle of the cycle, 5 entries buffered
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.wen !== 4'b0000 || bus.fu_ready !== 6'b111111 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async wen=%b ready=%b busy=%b want 0000/111111/0", bus.wen, bus.fu_ready, bus.busy);
    end
    do_reset();
    for (int i = 0; i < NUM_FU; i++) offer(i, PRN_BITS'(8 * i + 2), 64'(300 + i));
    step();
    clear_inputs();
    step();
    checks++;
    if (bus.wen !== 4'b1111 || bus.wprn[0] !== PRN_BITS'(2) || bus.wdata[0] !== 64'd300) begin
      errors++;
      $display("FAIL reset_first_grant wen=%b wprn0=%0d wdata0=%0d want 1111/2/300", bus.wen, bus.wprn[0], bus.wdata[0]);
    end
    step();
    checks++;
    if (bus.wen !== 4'b0011 || bus.wprn[0] !== PRN_BITS'(34) || bus.wprn[1] !== PRN_BITS'(42)) begin
      errors++;
      $display("FAIL reset_second_grant wen=%b wprn0=%0d wprn1=%0d want 0011/34/42", bus.wen, bus.wprn[0], bus.wprn[1]);
    end
    step();
    checks++;
    if (bus.wen !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain wen=%b busy=%b want 0000/0", bus.wen, bus.busy);
    end
  endtask

  task automatic test_single();
    clear_inputs();
    offer(2, PRN_BITS'(5), 64'hDEAD);
    step();
    clear_inputs();
    checks++;
    if (bus.wen !== 4'b0000 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency wen=%b busy=%b want 0000/1", bus.wen, bus.busy);
    end
    step();
    checks++;
    if (bus.wen !== 4'b0001 || bus.wprn[0] !== PRN_BITS'(5) || bus.wdata[0] !== 64'hDEAD) begin
      errors++;
      $display("FAIL single_write wen=%b wprn0=%0d wdata0=%h want 0001/5/dead", bus.wen, bus.wprn[0], bus.wdata[0]);
    end
    step();
    checks++;
    if (bus.wen !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle wen=%b busy=%b want 0000/0", bus.wen, bus.busy);
    end
    // scan now starts at FU3, so FU4 must beat FU1 to port 0
    offer(1, PRN_BITS'(10), 64'hA1);
    offer(4, PRN_BITS'(11), 64'hA4);
    step();
    clear_inputs();
    step();
    checks++;
    if (bus.wen !== 4'b0011 || bus.wprn[0] !== PRN_BITS'(11) || bus.wprn[1] !== PRN_BITS'(10)) begin
      errors++;
      $display("FAIL single_rr_ptr wen=%b wprn0=%0d wprn1=%0d want 0011/11/10", bus.wen, bus.wprn[0], bus.wprn[1]);
    end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NUM_FU; i++) offer(i, PRN_BITS'(8 * i + 1), {32'hFEED, 32'(i)});
    step();
    clear_inputs();
    step();
    for (int k = 0; k < W_PORTS; k++) begin
      checks++;
      if (bus.wen[k] !== 1'b1 || bus.wprn[k] !== PRN_BITS'(8 * k + 1) || bus.wdata[k] !== {32'hFEED, 32'(k)}) begin
        errors++;
        $display("FAIL rr_first port%0d wen=%b wprn=%0d want 1/%0d", k, bus.wen[k], bus.wprn[k], 8 * k + 1);
      end
    end
    step();
    checks++;
    if (bus.wen !== 4'b0011 || bus.wprn[0] !== PRN_BITS'(33) || bus.wprn[1] !== PRN_BITS'(41)) begin
      errors++;
      $display("FAIL rr_second wen=%b wprn0=%0d wprn1=%0d want 0011/33/41", bus.wen, bus.wprn[0], bus.wprn[1]);
    end
    // pointer wrapped back to FU0
    for (int i = 0; i < NUM_FU; i++) offer(i, PRN_BITS'(8 * i + 2), 64'(i));
    step();
    clear_inputs();
    step();
    checks++;
    if (bus.wen !== 4'b1111 || bus.wprn[0] !== PRN_BITS'(2)) begin
      errors++;
      $display("FAIL rr_wrap wen=%b wprn0=%0d want 1111/2", bus.wen, bus.wprn[0]);
    end
    step();
    step();
  endtask

  task automatic test_saturation();
    int seq  [NUM_FU];
    int acc_n[NUM_FU];
    int wr_n [NUM_FU];
    int win_n[NUM_FU];
    logic [NUM_FU-1:0] acc;
    int fu;
    do_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      seq[i] = 0; acc_n[i] = 0; wr_n[i] = 0; win_n[i] = 0;
      offer(i, PRN_BITS'(8 * i), {32'(i), 32'd0});
    end
    for (int c = 0; c < 36; c++) begin
      if (c == 30) clear_inputs();
      acc = model_ready() & bus.fu_valid;
      step();
      for (int i = 0; i < NUM_FU; i++) begin
        if (acc[i]) begin
          acc_n[i]++;
          seq[i]++;
          if (c < 29) offer(i, PRN_BITS'(8 * i + (seq[i] % 8)), {32'(i), 32'(seq[i])});
        end
      end
      for (int k = 0; k < W_PORTS; k++) begin
        checks++;
        if (bus.wen[k] !== exp_wen[k]) begin
          errors++;
          $display("FAIL sat_wen port%0d cyc%0d got %b want %b", k, c, bus.wen[k], exp_wen[k]);
        end else if (exp_wen[k]) begin
          checks++;
          if (bus.wprn[k] !== exp_prn[k] || bus.wdata[k] !== exp_data[k]) begin
            errors++;
            $display("FAIL sat_entry port%0d cyc%0d got %0d/%h want %0d/%h", k, c, bus.wprn[k], bus.wdata[k], exp_prn[k], exp_data[k]);
          end
          fu = int'(bus.wprn[k]) / 8;
          if (fu < NUM_FU) begin
            wr_n[fu]++;
            if (c >= 6 && c <= 23) win_n[fu]++;
          end
        end
      end
      checks++;
      if (bus.fu_ready !== model_ready()) begin
        errors++;
        $display("FAIL sat_ready cyc%0d got %b want %b", c, bus.fu_ready, model_ready());
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      checks++;
      if (wr_n[i] !== acc_n[i] || win_n[i] !== 12) begin
        errors++;
        $display("FAIL sat_count fu%0d written %0d accepted %0d window %0d want window 12", i, wr_n[i], acc_n[i], win_n[i]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sat_drained busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    offer(4, PRN_BITS'(44), 64'h44);
    offer(5, PRN_BITS'(45), 64'h45);
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) offer(i, PRN_BITS'(50 + i), 64'(500 + i));
    step();
    checks++;
    if (bus.wen !== 4'b0011) begin
      errors++;
      $display("FAIL flush_setup wen got %b want 0011", bus.wen);
    end
    clear_inputs();
    offer(1, PRN_BITS'(60), 64'hBAD1);
    flush = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.wen !== 4'b0000 || bus.busy !== 1'b0 || bus.fu_ready !== 6'b111111) begin
      errors++;
      $display("FAIL flush_clear wen=%b busy=%b ready=%b want 0000/0/111111", bus.wen, bus.busy, bus.fu_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.wen !== 4'b0000) begin
        errors++;
        $display("FAIL flush_no_write cyc%0d wen got %b want 0000", c, bus.wen);
      end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    offer(1, PRN_BITS'(20), 64'h1);
    step();
    clear_inputs();
    step();
    checks++;
    if (bus.wen !== 4'b0001 || bus.wprn[0] !== PRN_BITS'(20)) begin
      errors++;
      $display("FAIL full_setup wen=%b wprn0=%0d want 0001/20", bus.wen, bus.wprn[0]);
    end
    offer(0, PRN_BITS'(30), 64'hF0A);
    for (int i = 2; i < NUM_FU; i++) offer(i, PRN_BITS'(40 + i), 64'(i));
    step();
    clear_inputs();
    offer(0, PRN_BITS'(31), 64'hF0B);
    step();
    checks++;
    if (bus.wen !== 4'b1111 || bus.wprn[0] !== PRN_BITS'(42) || bus.fu_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_not_ready wen=%b wprn0=%0d ready0=%b want 1111/42/0", bus.wen, bus.wprn[0], bus.fu_ready[0]);
    end
    offer(0, PRN_BITS'(32), 64'hF0C);
    step();
    clear_inputs();
    checks++;
    if (bus.wen !== 4'b0001 || bus.wprn[0] !== PRN_BITS'(30) || bus.wdata[0] !== 64'hF0A || bus.fu_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_pop wen=%b wprn0=%0d ready0=%b want 0001/30/1", bus.wen, bus.wprn[0], bus.fu_ready[0]);
    end
    step();
    checks++;
    if (bus.wen !== 4'b0001 || bus.wprn[0] !== PRN_BITS'(31) || bus.wdata[0] !== 64'hF0B) begin
      errors++;
      $display("FAIL full_second wen=%b wprn0=%0d want 0001/31", bus.wen, bus.wprn[0]);
    end
    step();
    checks++;
    if (bus.wen !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_dropped wen=%b busy=%b want 0000/0", bus.wen, bus.busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      if (c < 390) begin
        for (int i = 0; i < NUM_FU; i++) begin
          if ($urandom_range(0, 1) == 1) offer(i, PRN_BITS'($urandom), {$urandom, $urandom});
        end
        flush = ($urandom_range(0, 19) == 0);
      end
      step();
      for (int k = 0; k < W_PORTS; k++) begin
        checks++;
        if (bus.wen[k] !== exp_wen[k]) begin
          errors++;
          $display("FAIL rnd_wen port%0d cyc%0d got %b want %b", k, c, bus.wen[k], exp_wen[k]);
        end else if (exp_wen[k]) begin
          checks++;
          if (bus.wprn[k] !== exp_prn[k] || bus.wdata[k] !== exp_data[k]) begin
            errors++;
            $display("FAIL rnd_entry port%0d cyc%0d got %0d/%h want %0d/%h", k, c, bus.wprn[k], bus.wdata[k], exp_prn[k], exp_data[k]);
          end
        end
      end
      checks++;
      if (bus.fu_ready !== model_ready() || bus.busy !== model_busy()) begin
        errors++;
        $display("FAIL rnd_status cyc%0d ready=%b busy=%b want %b/%b", c, bus.fu_ready, bus.busy, model_ready(), model_busy());
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_flush();
    test_full_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prf_wb_arbiter.md
Name: prf_wb_arbiter

Overview:
Writeback-side initiator for the physical register file. It collects completed results (PRN plus 64-bit data) from NUM_FU functional units through per-unit skid FIFOs. It arbitrates them round-robin onto W_PORTS registered PRF write ports, and those ports double as the wakeup broadcast. It sits between the execution units and the PRF write ports, and drains on pipeline flush.

Parameters:
NUM_FU, 6, number of functional-unit result sources
W_PORTS, 4, number of PRF write ports driven per cycle (W_PORTS <= NUM_FU)
FIFO_DEPTH, 2, entries per source FIFO (power of two, >= 2)
PRN_BITS, 6, physical register number width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all buffered results
fu_valid[NUM_FU]  input  1 each  result offered by unit i
fu_prn[NUM_FU]  input  PRN_BITS each  destination PRN
fu_data[NUM_FU]  input  64 each  result value
fu_ready[NUM_FU]  output  1 each  unit i FIFO can accept
wen[W_PORTS]  output  1 each  PRF write enable, registered
wprn[W_PORTS]  output  PRN_BITS each  PRF write PRN, registered
wdata[W_PORTS]  output  64 each  PRF write data, registered
busy  output  1  any FIFO non-empty or any wen asserted

Behaviour:
- Reset is asynchronous on rst_n low:
  - all FIFOs empty, rr_ptr = 0
  - wen all 0, wprn/wdata all 0, busy 0, fu_ready all 1
  - reset mid-operation discards all buffered results
- Push handshake: an entry is accepted at an edge where fu_valid[i] && fu_ready[i] && !flush.
- fu_ready[i] = (count[i] < FIFO_DEPTH), taken from registered count only.
  - No combinational path from same-cycle pop; a full FIFO stays not-ready even if it is popped that cycle.
- Each FIFO preserves order per source. A pop and a push in the same cycle are both legal (count unchanged).
- Arbitration is combinational on the FIFO heads, each cycle:
  - scan sources rr_ptr, rr_ptr+1, ... mod NUM_FU
  - grant the first up to W_PORTS non-empty sources
  - at most one pop per source per cycle
  - the k-th granted source goes to port k; unused ports get wen = 0
- Pointer update: rr_ptr <= (index of last granted source + 1) mod NUM_FU; unchanged if nothing is granted.
- Output registers load granted head PRN/data and set wen at the grant edge. Result: push sampled at edge E0 gives wen high in the cycle after edge E1 (2-cycle latency minimum), held exactly one cycle per entry.
- wprn/wdata hold their previous values when wen = 0. The bench checks them only when wen = 1.
- flush:
  - at the edge it is sampled, all FIFOs are emptied and no grants or pushes are taken that cycle
  - next cycle: wen all 0, fu_ready all 1
  - rr_ptr unchanged
- Duplicate PRNs granted in one cycle are illegal upstream (rename guarantees uniqueness). No check is made; the PRF resolves them with the highest port winning.
- busy = OR of (count[i] != 0) and OR of wen[].
- Width rules: rr_ptr is clog2(NUM_FU) bits with explicit mod wrap (NUM_FU need not be a power of two). FIFO pointers are clog2(FIFO_DEPTH) bits, and count is clog2(FIFO_DEPTH)+1 bits.

Test Plan:
(defaults: NUM_FU=6, W_PORTS=4, FIFO_DEPTH=2)
1. Reset: assert rst_n=0 asynchronously with 5 entries buffered and wen active. Required: wen=0 and fu_ready=6'b111111 immediately; busy=0; after release the first grant starts at FU0.
2. Single result: FU2 pushes prn=5, data=0xDEAD at edge k. Required: wen[0]=1, wprn[0]=5, wdata[0]=0xDEAD in the cycle after edge k+1, for exactly one cycle; wen[1..3]=0; rr_ptr becomes 3.
3. Round-robin: all 6 FUs push one entry at the same edge, with rr_ptr=0. Required:
   - first write cycle: ports 0-3 carry FU0-FU3
   - next cycle: ports 0-1 carry FU4, FU5
   - rr_ptr ends at 0
4. Saturation: all FUs hold fu_valid=1 with unique PRNs for 30 cycles. Required:
   - fu_ready drops only when a FIFO is full; no entry is lost or duplicated
   - per-FU order is preserved
   - each FU receives 2 grants per 3 cycles in steady state
5. Flush: 4 entries are buffered and FU1 pushes in the flush cycle. Required: next cycle wen=0, busy=0, fu_ready all 1; FU1's entry is never written.
6. Full FIFO with pop: FU0 is full (count=2) while it is granted. Required: fu_ready[0]=0 that cycle, no push is taken, and count becomes 1 with ready=1 on the next cycle.
